warp_scheduler: RTL and testbench

// Sequences the per-warp pipeline states (warp_state) that gate register-file reads/writes, ALU and LSU.

---
 rtl/warp_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_warp_scheduler.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/warp_scheduler.sv
// warp_scheduler: per-warp pipeline sequencer for one core.
// Holds one PC per warp, issues one warp at a time through
// FETCH..UPDATE and round-robins to the next live warp.
// Optional feature macro: WARP_SCHED_PERF_EN (adds perf_issued/perf_stall counters).

package warp_scheduler_pkg;
    typedef enum logic [2:0] {
        WARP_IDLE    = 3'd0,
        WARP_FETCH   = 3'd1,
        WARP_DECODE  = 3'd2,
        WARP_REQUEST = 3'd3,
        WARP_WAIT    = 3'd4,
        WARP_EXECUTE = 3'd5,
        WARP_UPDATE  = 3'd6,
        WARP_DONE    = 3'd7
    } warp_state_t;

    typedef enum logic [1:0] {
        SCHED_IDLE   = 2'd0,
        SCHED_RUN    = 2'd1,
        SCHED_FINISH = 2'd2
    } sched_state_t;
endpackage

// Handshake notes: start is a single-cycle request accepted only while the
// scheduler is IDLE or FINISH (ignored in RUN). fetch_req stays high while the
// issued warp is in FETCH; fetch_valid completes that fetch on the cycle it is
// seen high. lsu_busy holds the issued warp in WAIT for as long as it is high.
module warp_scheduler
    import warp_scheduler_pkg::*;
#(
    parameter int NUM_WARPS = 4,
    parameter int PC_WIDTH  = 8,
    localparam int NW_W = $clog2(NUM_WARPS + 1),
    localparam int CW_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [PC_WIDTH-1:0]  start_pc,
    input  logic [NW_W-1:0]      num_warps,
    output logic                 fetch_req,
    output logic [PC_WIDTH-1:0]  fetch_pc,
    input  logic                 fetch_valid,
    input  logic                 decoded_halt,
    input  logic                 decoded_branch,
    input  logic [PC_WIDTH-1:0]  branch_target,
    input  logic                 lsu_busy,
    output logic [NUM_WARPS-1:0] warp_enable,
    output warp_state_t          warp_state,
    output logic [CW_W-1:0]      cur_warp,
    output logic                 done,
`ifdef WARP_SCHED_PERF_EN
    output logic [31:0]          perf_issued,
    output logic [31:0]          perf_stall,
`endif
    output sched_state_t         dbg_sched_state
);

    sched_state_t        sched_q, sched_d;
    warp_state_t         st_q [NUM_WARPS];
    warp_state_t         st_d [NUM_WARPS];
    logic [PC_WIDTH-1:0] pc_q [NUM_WARPS];
    logic [PC_WIDTH-1:0] pc_d [NUM_WARPS];
    logic [CW_W-1:0]     cur_q, cur_d;
    logic [NW_W-1:0]     num_clamped;
    logic                start_accept;
    logic                found;
    logic [CW_W-1:0]     idx;

    assign num_clamped  = (num_warps > NW_W'(NUM_WARPS)) ? NW_W'(NUM_WARPS) : num_warps;
    assign start_accept = start && (sched_q != SCHED_RUN);

    // State registers: scheduler FSM, per-warp states, PCs and issue pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            sched_q <= SCHED_IDLE;
            cur_q   <= '0;
            for (int i = 0; i < NUM_WARPS; i++) begin
                st_q[i] <= WARP_IDLE;
                pc_q[i] <= '0;
            end
        end else begin
            sched_q <= sched_d;
            cur_q   <= cur_d;
            for (int i = 0; i < NUM_WARPS; i++) begin
                st_q[i] <= st_d[i];
                pc_q[i] <= pc_d[i];
            end
        end
    end

    // Next-state: launch, issued-warp pipeline step, PC update and round-robin pick.
    always_comb begin
        sched_d = sched_q;
        cur_d   = cur_q;
        found   = 1'b0;
        idx     = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            st_d[i] = st_q[i];
            pc_d[i] = pc_q[i];
        end

        case (sched_q)
            SCHED_IDLE, SCHED_FINISH: begin
                if (start) begin
                    cur_d = '0;
                    for (int i = 0; i < NUM_WARPS; i++) begin
                        if (NW_W'(i) < num_clamped) begin
                            st_d[i] = WARP_FETCH;
                            pc_d[i] = start_pc;
                        end else begin
                            st_d[i] = WARP_DONE;
                        end
                    end
                    sched_d = (num_clamped == '0) ? SCHED_FINISH : SCHED_RUN;
                end
            end
            SCHED_RUN: begin
                case (st_q[cur_q])
                    WARP_FETCH:   if (fetch_valid) st_d[cur_q] = WARP_DECODE;
                    WARP_DECODE:  st_d[cur_q] = WARP_REQUEST;
                    WARP_REQUEST: st_d[cur_q] = WARP_WAIT;
                    WARP_WAIT:    if (!lsu_busy) st_d[cur_q] = WARP_EXECUTE;
                    WARP_EXECUTE: st_d[cur_q] = WARP_UPDATE;
                    WARP_UPDATE: begin
                        // Halt wins over branch and leaves the PC untouched.
                        if (decoded_halt) begin
                            st_d[cur_q] = WARP_DONE;
                        end else begin
                            st_d[cur_q] = WARP_FETCH;
                            pc_d[cur_q] = decoded_branch ? branch_target
                                                         : pc_q[cur_q] + PC_WIDTH'(1);
                        end
                        // Offset NUM_WARPS lands back on cur_q, so a sole live warp re-issues.
                        for (int k = 1; k <= NUM_WARPS; k++) begin
                            idx = CW_W'((int'(cur_q) + k) % NUM_WARPS);
                            if (!found && (st_d[idx] != WARP_DONE)) begin
                                found = 1'b1;
                                cur_d = idx;
                            end
                        end
                        if (!found) sched_d = SCHED_FINISH;
                    end
                    default: ;
                endcase
            end
            default: sched_d = SCHED_IDLE;
        endcase
    end

    // Outputs are decoded from registers only; reset additionally drops fetch_req at once.
    always_comb begin
        fetch_req   = (sched_q == SCHED_RUN) && (st_q[cur_q] == WARP_FETCH) && !reset;
        fetch_pc    = pc_q[cur_q];
        warp_state  = st_q[cur_q];
        cur_warp    = cur_q;
        done        = (sched_q == SCHED_FINISH);
        warp_enable = (sched_q == SCHED_RUN) ? (NUM_WARPS'(1) << cur_q) : '0;
    end

    assign dbg_sched_state = sched_q;

`ifdef WARP_SCHED_PERF_EN
    logic [31:0] perf_issued_q, perf_stall_q;
    logic        stall_now;

    assign stall_now = (sched_q == SCHED_RUN) &&
                       (((st_q[cur_q] == WARP_FETCH) && !fetch_valid) ||
                        ((st_q[cur_q] == WARP_WAIT)  && lsu_busy));

    // Saturating issue/stall counters, cleared on reset and on an accepted launch.
    always_ff @(posedge clk) begin
        if (reset || start_accept) begin
            perf_issued_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            if ((sched_q == SCHED_RUN) && (st_q[cur_q] == WARP_UPDATE) && (perf_issued_q != '1))
                perf_issued_q <= perf_issued_q + 32'd1;
            if (stall_now && (perf_stall_q != '1))
                perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_issued = perf_issued_q;
    assign perf_stall  = perf_stall_q;
`else
    logic unused_start_accept;
    assign unused_start_accept = start_accept;
`endif

endmodule

// File: tb/tb_warp_scheduler.sv
// tb_warp_scheduler: randomized self-checking bench for warp_scheduler.
// The reference model works per instruction: it knows each warp's PC and
// liveness, derives the expected cycle-by-cycle state sequence from the
// fetch/LSU stall lengths, and picks the next warp by round-robin search.

module tb_warp_scheduler;
    import warp_scheduler_pkg::*;

    localparam int NW = 4;
    localparam int PW = 8;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [PW-1:0] start_pc;
    logic [2:0]    num_warps;
    logic          fetch_req;
    logic [PW-1:0] fetch_pc;
    logic          fetch_valid;
    logic          decoded_halt;
    logic          decoded_branch;
    logic [PW-1:0] branch_target;
    logic          lsu_busy;
    logic [NW-1:0] warp_enable;
    warp_state_t   warp_state;
    logic [1:0]    cur_warp;
    logic          done;
    sched_state_t  dbg_sched_state;
`ifdef WARP_SCHED_PERF_EN
    logic [31:0]   perf_issued;
    logic [31:0]   perf_stall;
`endif

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    warp_scheduler #(.NUM_WARPS(NW), .PC_WIDTH(PW)) dut (
        .clk(clk), .reset(reset), .start(start), .start_pc(start_pc),
        .num_warps(num_warps), .fetch_req(fetch_req), .fetch_pc(fetch_pc),
        .fetch_valid(fetch_valid), .decoded_halt(decoded_halt),
        .decoded_branch(decoded_branch), .branch_target(branch_target),
        .lsu_busy(lsu_busy), .warp_enable(warp_enable), .warp_state(warp_state),
        .cur_warp(cur_warp), .done(done),
`ifdef WARP_SCHED_PERF_EN
        .perf_issued(perf_issued), .perf_stall(perf_stall),
`endif
        .dbg_sched_state(dbg_sched_state)
    );

    int n_vec = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    logic [PW-1:0] m_pc [NW];
    bit            m_alive [NW];
    int            m_cur;
    bit            m_running;
    logic [1:0]    exp_q[$];

    // ---------------- driver tasks ----------------
    task automatic drive_quiet();
        start          = 1'b0;
        fetch_valid    = 1'b0;
        decoded_halt   = 1'b0;
        decoded_branch = 1'b0;
        branch_target  = '0;
        lsu_busy       = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_kernel(input int n, input logic [PW-1:0] pc);
        int nn;
        nn = (n > NW) ? NW : n;
        num_warps = 3'(n);
        start_pc  = pc;
        start     = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < NW; i++) begin
            m_alive[i] = (i < nn);
            if (i < nn) m_pc[i] = pc;
        end
        m_cur     = 0;
        m_running = (nn > 0);
        n_vec++;
        if (done !== (nn == 0)) begin
            n_err++;
            $display("FAIL start_done n=%0d: got %b want %b", n, done, nn == 0);
        end
        n_vec++;
        if (warp_state !== (nn == 0 ? WARP_DONE : WARP_FETCH)) begin
            n_err++;
            $display("FAIL start_state n=%0d: got %s", n, warp_state.name());
        end
        n_vec++;
        if (cur_warp !== 2'd0 || warp_enable !== (nn == 0 ? 4'b0000 : 4'b0001)) begin
            n_err++;
            $display("FAIL start_issue n=%0d: cur %0d en %b", n, cur_warp, warp_enable);
        end
        if (nn > 0) begin
            n_vec++;
            if (fetch_pc !== pc || fetch_req !== 1'b1) begin
                n_err++;
                $display("FAIL start_pc: got pc %h req %b want pc %h req 1", fetch_pc, fetch_req, pc);
            end
        end
    endtask

    // One instruction of the issued warp: d fetch-wait cycles, s LSU-busy cycles.
    task automatic run_instr(input int d, input int s, input bit halt, input bit br,
                             input logic [PW-1:0] tgt, input bit pulse_start);
        int            total;
        int            ew;
        logic [PW-1:0] epc;
        warp_state_t   es;
        logic [NW-1:0] een;
        bit            found;
        ew    = m_cur;
        epc   = m_pc[m_cur];
        een   = 4'b0001 << ew;
        total = d + s + 6;
        for (int k = 0; k < total; k++) begin
            if (k <= d)              es = WARP_FETCH;
            else if (k == d + 1)     es = WARP_DECODE;
            else if (k == d + 2)     es = WARP_REQUEST;
            else if (k <= d + 3 + s) es = WARP_WAIT;
            else if (k == d + 4 + s) es = WARP_EXECUTE;
            else                     es = WARP_UPDATE;
            fetch_valid    = (k == d);
            lsu_busy       = (k >= d + 3) && (k < d + 3 + s);
            decoded_halt   = halt;
            decoded_branch = br;
            branch_target  = tgt;
            start          = pulse_start && (k == 1);
            start_pc       = 8'h99;
            num_warps      = 3'd1;
            n_vec++;
            if (warp_state !== es) begin
                n_err++;
                $display("FAIL state w%0d k=%0d: got %s want %s", ew, k, warp_state.name(), es.name());
            end
            n_vec++;
            if (cur_warp !== 2'(ew) || warp_enable !== een) begin
                n_err++;
                $display("FAIL issue k=%0d: cur %0d en %b want cur %0d en %b", k, cur_warp, warp_enable, ew, een);
            end
            n_vec++;
            if (fetch_pc !== epc || fetch_req !== (es == WARP_FETCH) || done !== 1'b0) begin
                n_err++;
                $display("FAIL fetch w%0d k=%0d: pc %h req %b done %b want pc %h req %b done 0",
                         ew, k, fetch_pc, fetch_req, done, epc, es == WARP_FETCH);
            end
            step();
        end
        drive_quiet();
        if (halt) m_alive[ew] = 0;
        else      m_pc[ew] = br ? tgt : PW'(epc + 1);
        found = 0;
        for (int k = 1; k <= NW; k++) begin
            if (!found && m_alive[(ew + k) % NW]) begin
                found = 1;
                m_cur = (ew + k) % NW;
            end
        end
        m_running = found;
        if (!m_running) begin
            n_vec++;
            if (done !== 1'b1 || warp_state !== WARP_DONE || warp_enable !== '0 || fetch_req !== 1'b0) begin
                n_err++;
                $display("FAIL finish: done %b state %s en %b req %b want done 1 DONE en 0 req 0",
                         done, warp_state.name(), warp_enable, fetch_req);
            end
        end
    endtask

    task automatic halt_all();
        for (int i = 0; i < 2 * NW && m_running; i++) run_instr(0, 0, 1'b1, 1'b0, '0, 1'b0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        drive_quiet();
        num_warps = '0;
        start_pc  = '0;
        step();
        step();
        reset = 1'b0;
        n_vec++;
        if (fetch_req !== 1'b0 || warp_enable !== '0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctl: req %b en %b done %b want 0 0 0", fetch_req, warp_enable, done);
        end
        n_vec++;
        if (warp_state !== WARP_IDLE || cur_warp !== 2'd0 || fetch_pc !== 8'h00) begin
            n_err++;
            $display("FAIL reset_state: %s cur %0d pc %h want WARP_IDLE 0 00", warp_state.name(), cur_warp, fetch_pc);
        end
        m_running = 0;
    endtask

    task automatic test_single_warp();
        int c0;
        c0 = cyc;
        start_kernel(1, 8'h10);
        run_instr(0, 0, 1'b0, 1'b0, '0, 1'b0);
        run_instr(0, 0, 1'b0, 1'b0, '0, 1'b0);
        run_instr(0, 0, 1'b1, 1'b0, '0, 1'b0);
        n_vec++;
        if (!done || (cyc - c0) != 19) begin
            n_err++;
            $display("FAIL single_latency: done %b at cycle %0d want done 1 at 19", done, cyc - c0);
        end
    endtask

    task automatic test_round_robin();
        start_kernel(3, 8'h20);
        for (int i = 0; i < 6; i++) begin
            n_vec++;
            if (cur_warp !== 2'(i % 3)) begin
                n_err++;
                $display("FAIL rr_order i=%0d: got %0d want %0d", i, cur_warp, i % 3);
            end
            run_instr($urandom_range(0, 2), $urandom_range(0, 2), 1'b0, 1'b0, '0, 1'b0);
        end
        n_vec++;
        if (fetch_pc !== 8'h22) begin
            n_err++;
            $display("FAIL rr_pc: got %h want 22", fetch_pc);
        end
        halt_all();
    endtask

    task automatic test_halt_skip();
        exp_q = {2'd0, 2'd1, 2'd2, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd2};
        start_kernel(3, 8'h00);
        for (int i = 0; i < 9; i++) begin
            logic [1:0] ew;
            ew = exp_q.pop_front();
            n_vec++;
            if (cur_warp !== ew) begin
                n_err++;
                $display("FAIL skip_order i=%0d: got %0d want %0d", i, cur_warp, ew);
            end
            // warp 1 halts on its first issue; warps 0 and 2 halt on their last
            run_instr(0, 0, (i == 1) || (i >= 7), 1'b0, '0, 1'b0);
        end
    endtask

    task automatic test_stalls();
        start_kernel(1, 8'h30);
        run_instr(3, 4, 1'b0, 1'b0, '0, 1'b0);
        run_instr(1, 1, 1'b1, 1'b0, '0, 1'b0);
    endtask

    task automatic test_branch();
        start_kernel(1, 8'h30);
        run_instr(0, 0, 1'b1, 1'b1, 8'h40, 1'b0);
        n_vec++;
        if (fetch_pc !== 8'h30) begin
            n_err++;
            $display("FAIL halt_over_branch pc: got %h want 30", fetch_pc);
        end
        start_kernel(1, 8'hFE);
        run_instr(0, 0, 1'b0, 1'b1, 8'hFF, 1'b0);
        run_instr(0, 0, 1'b0, 1'b0, '0, 1'b0);
        n_vec++;
        if (fetch_pc !== 8'h00) begin
            n_err++;
            $display("FAIL pc_wrap: got %h want 00", fetch_pc);
        end
        halt_all();
    endtask

    task automatic test_start_ignored_and_zero();
        start_kernel(2, 8'h50);
        run_instr(0, 1, 1'b0, 1'b0, '0, 1'b1);
        run_instr(1, 0, 1'b0, 1'b0, '0, 1'b1);
        halt_all();
        start_kernel(0, 8'h77);
        start_kernel(7, 8'h60);
        n_vec++;
        if (dbg_sched_state !== SCHED_RUN) begin
            n_err++;
            $display("FAIL clamp_run: got %s want SCHED_RUN", dbg_sched_state.name());
        end
        halt_all();
    endtask

    task automatic test_reset_mid();
        start_kernel(3, 8'h80);
        run_instr(0, 0, 1'b0, 1'b0, '0, 1'b0);
        run_instr(0, 0, 1'b0, 1'b0, '0, 1'b0);
        fetch_valid = 1'b1;
        lsu_busy    = 1'b1;
        for (int k = 0; k < 4; k++) step();
        n_vec++;
        if (warp_state !== WARP_WAIT || cur_warp !== 2'd2) begin
            n_err++;
            $display("FAIL mid_wait: %s cur %0d want WARP_WAIT 2", warp_state.name(), cur_warp);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive_quiet();
        n_vec++;
        if (warp_state !== WARP_IDLE || warp_enable !== '0 || fetch_req !== 1'b0 ||
            done !== 1'b0 || cur_warp !== 2'd0 || fetch_pc !== 8'h00) begin
            n_err++;
            $display("FAIL mid_reset: %s en %b req %b done %b cur %0d pc %h",
                     warp_state.name(), warp_enable, fetch_req, done, cur_warp, fetch_pc);
        end
        m_running = 0;
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            int guard;
            start_kernel($urandom_range(0, 5), 8'($urandom_range(0, 255)));
            guard = 0;
            while (m_running && guard < 60) begin
                run_instr($urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                          8'($urandom_range(0, 255)), $urandom_range(0, 4) == 0);
                guard++;
            end
            if (m_running) begin
                n_vec++;
                n_err++;
                $display("FAIL random_bound: kernel %0d did not finish in %0d instructions", r, guard);
                test_reset();
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset = 1'b1;
        drive_quiet();
        num_warps = '0;
        start_pc  = '0;
        step();
        test_reset();
        test_single_warp();
        test_round_robin();
        test_halt_skip();
        test_stalls();
        test_branch();
        test_start_ignored_and_zero();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
